axi_slave_wr_router: RTL
========================

AXI_SLAVE_WR_ROUTER -- requirements
Module: axi_slave_wr_router

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_WIDTH, default 1024, W data width (routed externally; used only for documentation and checks).
- ADDR_WIDTH, default 64, AW address width.
- ID_WIDTH, default 8, B ID width.
- USER_WIDTH, default 8, B user width.
- SEL_BIT, default 31, address bit that selects slave 0 (bit=0) or slave 1 (bit=1).
REQ-002 Ports SHALL be, one per line (sN = s0 and s1, identical):
- ACLK  in  1  clock; one clock, all logic on rising edge.
- ARESET  in  1  reset, asynchronous, active-high.
- s_AWADDR  in  ADDR_WIDTH  master write address.
- s_AWLEN  in  8  master burst length minus 1.
- s_AWVALID  in  1  master AW valid.
- s_WVALID  in  1  master W valid.
- s_WLAST  in  1  master W last.
- s_BREADY  in  1  master B ready.
- m_AWREADY  out  1  AW ready to master.
- m_WREADY  out  1  W ready to master.
- m_BID / m_BRESP / m_BUSER  out  ID_WIDTH / 2 / USER_WIDTH  B payload to master.
- m_BVALID  out  1  B valid to master.
- sN_AWVALID / sN_WVALID / sN_BREADY  out  1 each  handshake to slave N.
- sN_AWREADY / sN_WREADY / sN_BVALID  in  1 each  handshake from slave N.
- sN_BID / sN_BRESP / sN_BUSER  in  ID_WIDTH / 2 / USER_WIDTH  B payload from slave N.
- m_wlen_err  out  1  sticky burst-length error (exists only with AXI_WR_ROUTER_LENCHK_EN).

Function
REQ-003 FSM states SHALL be IDLE, DATA and RESP; one write transaction is outstanding at most.
REQ-004 In IDLE, routing SHALL decode s_AWADDR[SEL_BIT] combinationally in the same cycle, with no one-cycle lag: the selected sN_AWVALID = s_AWVALID, the other = 0, and m_AWREADY = the selected sN_AWREADY.
REQ-005 On an AW handshake in IDLE, the block SHALL register sel = s_AWADDR[SEL_BIT] and beat count = s_AWLEN, then enter DATA.
REQ-006 In DATA, the selected sN_WVALID SHALL equal s_WVALID, and m_WREADY SHALL equal the selected sN_WREADY; the unselected slave sees 0.
REQ-007 A W handshake in DATA with s_WLAST=1 SHALL move the FSM to RESP; any other W handshake SHALL decrement the beat count.
REQ-008 In RESP, m_B* SHALL mirror the selected slave's B channel, and the selected sN_BREADY SHALL equal s_BREADY; a B handshake SHALL return the FSM to IDLE.
REQ-009 Outside IDLE, m_AWREADY and both sN_AWVALID SHALL be 0. Outside DATA, m_WREADY and both sN_WVALID SHALL be 0. Outside RESP, m_BVALID and both sN_BREADY SHALL be 0, and m_BID/m_BRESP/m_BUSER SHALL be 0.
REQ-010 W data presented before the AW handshake SHALL be stalled (m_WREADY=0) and SHALL NOT be forwarded.
REQ-011 When a B handshake and a new s_AWVALID occur in the same cycle, the new AW SHALL NOT be accepted until the following cycle, when the FSM is in IDLE.

Reset
REQ-012 ARESET SHALL asynchronously force state=IDLE, sel=0, beat count=0 and m_wlen_err=0.
REQ-013 While ARESET is high, every output SHALL be 0.
REQ-014 Reset asserted mid-burst SHALL abandon the transaction, with no further beats or B forwarded.

Configuration
REQ-015 With AXI_WR_ROUTER_LENCHK_EN defined, a WLAST handshake with beat count != 0, or a non-last handshake with beat count == 0, SHALL set m_wlen_err (sticky until reset), and the forwarded m_BRESP for that burst SHALL be forced to 2'b10 (SLVERR).
REQ-016 Without AXI_WR_ROUTER_LENCHK_EN, m_wlen_err SHALL be absent, the beat counter SHALL be absent, and BRESP SHALL pass through unchanged.

Structure
REQ-017 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, DATA=2'd1, RESP=2'd2) and the BRESP constants OKAY=2'b00 and SLVERR=2'b10.
REQ-018 The design SHALL be a single module with no sub-modules.

Verification
REQ-019 AWADDR=0x0000_1000, AWLEN=3, 4 beats, s0 BRESP=00 -> only s0 handshakes toggle, and m_BRESP=00 is seen once.
REQ-020 AWADDR=0x8000_0000, AWLEN=0 -> s1_AWVALID is asserted in the same cycle as s_AWVALID, and s0_AWVALID stays 0 throughout.
REQ-021 s_WVALID=1 for 3 cycles before s_AWVALID -> m_WREADY=0 until the cycle after the AW handshake.
REQ-022 B handshake coincident with a new s_AWVALID -> m_AWREADY=0 in that cycle, and the AW is accepted in the next cycle.
REQ-023 ARESET pulsed on beat 2 of a 4-beat burst -> all outputs are 0 immediately, and a subsequent burst to s1 completes normally.
REQ-024 With LENCHK_EN: AWLEN=3 and WLAST on beat 2 -> m_wlen_err=1 and m_BRESP=2'b10.

Source files
------------

// File: rtl/axi_slave_wr_router_pkg.sv
// Shared types and constants for the AXI write router: FSM state encoding
// and the BRESP codes the router can produce.
package axi_slave_wr_router_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_slave_wr_router.sv
// AXI write router: steers one write transaction at a time from a single
// master to one of two slaves, chosen by s_AWADDR[SEL_BIT].
// The AW decode is combinational, so the request reaches the slave in the
// cycle it is presented. W is held off until AW has been accepted, and B is
// routed back from the same slave.
// Optional feature: define AXI_WR_ROUTER_LENCHK_EN to add a beat counter that
// flags WLAST/AWLEN disagreement on m_wlen_err (sticky) and forces SLVERR.
module axi_slave_wr_router
    import axi_slave_wr_router_pkg::*;
#(
    parameter int DATA_WIDTH = 1024,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 8,
    parameter int USER_WIDTH = 8,
    parameter int SEL_BIT    = 31
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_WIDTH-1:0] s_AWADDR,
    input  logic [7:0]            s_AWLEN,
    input  logic                  s_AWVALID,
    input  logic                  s_WVALID,
    input  logic                  s_WLAST,
    input  logic                  s_BREADY,
    output logic                  m_AWREADY,
    output logic                  m_WREADY,
    output logic [ID_WIDTH-1:0]   m_BID,
    output logic [1:0]            m_BRESP,
    output logic [USER_WIDTH-1:0] m_BUSER,
    output logic                  m_BVALID,
    output logic                  s0_AWVALID,
    output logic                  s0_WVALID,
    output logic                  s0_BREADY,
    input  logic                  s0_AWREADY,
    input  logic                  s0_WREADY,
    input  logic                  s0_BVALID,
    input  logic [ID_WIDTH-1:0]   s0_BID,
    input  logic [1:0]            s0_BRESP,
    input  logic [USER_WIDTH-1:0] s0_BUSER,
    output logic                  s1_AWVALID,
    output logic                  s1_WVALID,
    output logic                  s1_BREADY,
    input  logic                  s1_AWREADY,
    input  logic                  s1_WREADY,
    input  logic                  s1_BVALID,
    input  logic [ID_WIDTH-1:0]   s1_BID,
    input  logic [1:0]            s1_BRESP,
    input  logic [USER_WIDTH-1:0] s1_BUSER
`ifdef AXI_WR_ROUTER_LENCHK_EN
    ,
    output logic                  m_wlen_err
`endif
);

    state_t state;
    logic   sel;        // 0 = slave 0, 1 = slave 1, valid outside IDLE
    logic   addr_sel;   // live address decode used while IDLE
    logic   aw_hs;
    logic   w_hs;
    logic   b_hs;

`ifdef AXI_WR_ROUTER_LENCHK_EN
    logic [7:0] beat_cnt;   // beats still expected after the current one
    logic       burst_err;  // this burst has violated its AWLEN
    logic       len_bad;
`endif

    // Width and unused-bit sink: only SEL_BIT of the address is decoded, and
    // DATA_WIDTH describes the externally routed W bus.
    logic unused_ok;
`ifdef AXI_WR_ROUTER_LENCHK_EN
    assign unused_ok = ^{s_AWADDR, 32'(DATA_WIDTH)};
`else
    assign unused_ok = ^{s_AWADDR, s_AWLEN, 32'(DATA_WIDTH), BRESP_SLVERR};
`endif

    assign addr_sel = s_AWADDR[SEL_BIT];

    // Handshakes are built from the gated outputs, so they can only fire in
    // the owning state and never while ARESET is high.
    assign aw_hs = s_AWVALID && m_AWREADY;
    assign w_hs  = s_WVALID  && m_WREADY;
    assign b_hs  = m_BVALID  && s_BREADY;

`ifdef AXI_WR_ROUTER_LENCHK_EN
    assign len_bad = s_WLAST ? (beat_cnt != 8'd0) : (beat_cnt == 8'd0);
`endif

    // Channel steering: each channel is open only in its own state, and every
    // output is forced low while ARESET is high.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // case leaves one unassigned and no latch is inferred.
        m_AWREADY  = 1'b0;
        m_WREADY   = 1'b0;
        m_BVALID   = 1'b0;
        m_BID      = '0;
        m_BRESP    = BRESP_OKAY;
        m_BUSER    = '0;
        s0_AWVALID = 1'b0;
        s0_WVALID  = 1'b0;
        s0_BREADY  = 1'b0;
        s1_AWVALID = 1'b0;
        s1_WVALID  = 1'b0;
        s1_BREADY  = 1'b0;
        if (!ARESET) begin
            case (state)
                IDLE: begin
                    s0_AWVALID = s_AWVALID && !addr_sel;
                    s1_AWVALID = s_AWVALID &&  addr_sel;
                    m_AWREADY  = addr_sel ? s1_AWREADY : s0_AWREADY;
                end
                DATA: begin
                    s0_WVALID = s_WVALID && !sel;
                    s1_WVALID = s_WVALID &&  sel;
                    m_WREADY  = sel ? s1_WREADY : s0_WREADY;
                end
                RESP: begin
                    s0_BREADY = s_BREADY && !sel;
                    s1_BREADY = s_BREADY &&  sel;
                    m_BVALID  = sel ? s1_BVALID : s0_BVALID;
                    m_BID     = sel ? s1_BID    : s0_BID;
                    m_BUSER   = sel ? s1_BUSER  : s0_BUSER;
`ifdef AXI_WR_ROUTER_LENCHK_EN
                    m_BRESP   = burst_err ? BRESP_SLVERR
                                          : (sel ? s1_BRESP : s0_BRESP);
`else
                    m_BRESP   = sel ? s1_BRESP : s0_BRESP;
`endif
                end
                default: ;
            endcase
        end
    end

    // Transaction FSM: AW accept -> W beats until WLAST -> B return.
    always_ff @(posedge ACLK or posedge ARESET) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (ARESET) begin
            state      <= IDLE;
            sel        <= 1'b0;
`ifdef AXI_WR_ROUTER_LENCHK_EN
            beat_cnt   <= 8'd0;
            burst_err  <= 1'b0;
            m_wlen_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        sel       <= addr_sel;
`ifdef AXI_WR_ROUTER_LENCHK_EN
                        beat_cnt  <= s_AWLEN;
                        burst_err <= 1'b0;
`endif
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
`ifdef AXI_WR_ROUTER_LENCHK_EN
                        if (len_bad) begin
                            burst_err  <= 1'b1;
                            m_wlen_err <= 1'b1;
                        end
                        if (!s_WLAST) begin
                            beat_cnt <= beat_cnt - 8'd1;
                        end
`endif
                        if (s_WLAST) begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
